// File: rtl/moving_average_pkg.sv
// moving_average_pkg: shared state encoding and derived sizing for the moving-average sequencer
package moving_average_pkg;

  typedef enum logic [2:0] {IDLE, CLEAR, FILL, RUN, DRAIN} state_t;

  // Output FIFO depth: covers the enable register, the LATENCY token stages and one slot to decouple downstream
  function automatic int fifo_depth(input int latency);
    return latency + 2;
  endfunction

endpackage

// File: rtl/ma_out_fifo.sv
// ma_out_fifo: first-word-fall-through result FIFO with occupancy count
module ma_out_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 3,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             wr, rd;

  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign wr      = wr_en && (count_q != CW'(DEPTH));
  assign rd      = rd_en && (count_q != '0);
  assign rd_data = mem_q[rd_ptr_q];
  assign count   = count_q;

  // Write at the tail, advance the head on read, track occupancy
  always_comb begin
    mem_d = mem_q;
    if (wr) mem_d[wr_ptr_q] = wr_data;
    wr_ptr_d = wr ? nxt(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = rd ? nxt(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q + CW'(wr) - CW'(rd);
  end

  // Storage and pointer registers; reset empties the FIFO and zeroes the head word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/moving_average_ctrl.sv
// moving_average_ctrl: run sequencer, warm-up suppression and credit-managed output buffering for moving_average
module moving_average_ctrl
  import moving_average_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int TAPS    = 4,
  parameter int LATENCY = 1,
  parameter int CNT_W   = 16
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Start,
  input  logic             Stop,
  input  logic             In_valid,
  output logic             In_ready,
  input  logic [WIDTH-1:0] In_data,
  output logic             Ma_clear,
  output logic             Ma_enable,
  output logic [WIDTH-1:0] Ma_X1,
  input  logic [WIDTH-1:0] Ma_Z,
  output logic             Out_valid,
  input  logic             Out_ready,
  output logic [WIDTH-1:0] Out_data,
  output logic             Busy,
  output logic [CNT_W-1:0] Sample_count
);

  localparam int DEPTH = fifo_depth(LATENCY);
  localparam int CRW   = $clog2(DEPTH + 1);

  state_t             state_q, state_d;
  logic               ma_clear_q, ma_clear_d;
  logic               ma_enable_q, ma_enable_d;
  logic               emit_q, emit_d;
  logic [WIDTH-1:0]   ma_x1_q, ma_x1_d;
  logic [LATENCY-1:0] tok_v_q, tok_v_d, tok_e_q, tok_e_d;
  logic [CRW-1:0]     credits_q, credits_d;
  logic [CNT_W-1:0]   sample_count_q, sample_count_d;
  logic               busy_q, busy_d;
  logic [CRW-1:0]     fifo_count;
  logic               acc, emit_now, retire, push, drop, pop;

  // Acceptance needs an open run and a free slot somewhere between datapath and FIFO
  assign In_ready = ((state_q == FILL) || (state_q == RUN)) && (credits_q < CRW'(DEPTH));
  assign acc      = In_valid && In_ready;
  assign emit_now = int'(sample_count_q) + 1 >= TAPS;
  assign retire   = tok_v_q[LATENCY-1];
  assign push     = retire && tok_e_q[LATENCY-1];
  assign drop     = retire && !tok_e_q[LATENCY-1];
  assign Out_valid = fifo_count != '0;
  assign pop      = Out_valid && Out_ready;

  assign Ma_clear     = ma_clear_q;
  assign Ma_enable    = ma_enable_q;
  assign Ma_X1        = ma_x1_q;
  assign Busy         = busy_q;
  assign Sample_count = sample_count_q;

  ma_out_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clk     (Clk),
    .rst_n   (Reset_n),
    .wr_en   (push),
    .wr_data (Ma_Z),
    .rd_en   (pop),
    .rd_data (Out_data),
    .count   (fifo_count)
  );

  // Run sequencing: Start only from IDLE, Stop only while accepting, drain until nothing is outstanding
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = Start ? CLEAR : IDLE;
      CLEAR:   state_d = FILL;
      FILL:    state_d = Stop ? DRAIN : (acc && emit_now) ? RUN : FILL;
      RUN:     state_d = Stop ? DRAIN : RUN;
      DRAIN:   state_d = (credits_q == '0) ? IDLE : DRAIN;
      default: state_d = IDLE;
    endcase
  end

  // Datapath strobes, token pipeline, credits and sample counter; entering CLEAR restarts the run bookkeeping
  always_comb begin
    ma_clear_d     = state_d == CLEAR;
    busy_d         = state_d != IDLE;
    ma_enable_d    = acc;
    emit_d         = acc && emit_now;
    ma_x1_d        = acc ? In_data : ma_x1_q;
    tok_v_d        = LATENCY'({tok_v_q, ma_enable_q});
    tok_e_d        = LATENCY'({tok_e_q, emit_q});
    credits_d      = (state_d == CLEAR) ? '0 : credits_q + CRW'(acc) - CRW'(pop) - CRW'(drop);
    sample_count_d = (state_d == CLEAR) ? '0 :
                     (acc && sample_count_q != '1) ? sample_count_q + 1'b1 : sample_count_q;
  end

  // Control registers; reset abandons any in-flight tokens
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q        <= IDLE;
      ma_clear_q     <= 1'b0;
      ma_enable_q    <= 1'b0;
      emit_q         <= 1'b0;
      ma_x1_q        <= '0;
      tok_v_q        <= '0;
      tok_e_q        <= '0;
      credits_q      <= '0;
      sample_count_q <= '0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      ma_clear_q     <= ma_clear_d;
      ma_enable_q    <= ma_enable_d;
      emit_q         <= emit_d;
      ma_x1_q        <= ma_x1_d;
      tok_v_q        <= tok_v_d;
      tok_e_q        <= tok_e_d;
      credits_q      <= credits_d;
      sample_count_q <= sample_count_d;
      busy_q         <= busy_d;
    end
  end

endmodule

// File: tb/tb_moving_average_ctrl.sv
// tb_moving_average_ctrl: directed scenarios against a 4-tap averaging datapath model
module tb_moving_average_ctrl;

  logic        Clk = 1'b0, Reset_n = 1'b0, Start = 1'b0, Stop = 1'b0;
  logic        In_valid = 1'b0, Out_ready = 1'b0;
  logic [7:0]  In_data = 8'd0;
  logic        In_ready, Ma_clear, Ma_enable, Out_valid, Busy;
  logic [7:0]  Ma_X1, Ma_Z, Out_data;
  logic [15:0] Sample_count;

  int checks = 0, fails = 0, cyc = 0, both_hi = 0, clr_cnt = 0;
  bit ov_seen = 1'b0;
  int acc_cyc[$], out_cyc[$];
  logic [7:0] out_q[$];

  logic [7:0] h0 = 8'd0, h1 = 8'd0, h2 = 8'd0, z_q = 8'd0;

  always #5 Clk = ~Clk;

  moving_average_ctrl #(.WIDTH(8), .TAPS(4), .LATENCY(1), .CNT_W(16)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .Stop(Stop),
    .In_valid(In_valid), .In_ready(In_ready), .In_data(In_data),
    .Ma_clear(Ma_clear), .Ma_enable(Ma_enable), .Ma_X1(Ma_X1), .Ma_Z(Ma_Z),
    .Out_valid(Out_valid), .Out_ready(Out_ready), .Out_data(Out_data),
    .Busy(Busy), .Sample_count(Sample_count)
  );

  // Datapath model: Z = (sum of last 4 samples) >> 2, one cycle after enable
  assign Ma_Z = z_q;
  always @(posedge Clk) begin
    if (Ma_clear) begin
      h0 <= 8'd0; h1 <= 8'd0; h2 <= 8'd0;
    end else if (Ma_enable) begin
      h0 <= Ma_X1; h1 <= h0; h2 <= h1;
      z_q <= 8'((10'(Ma_X1) + 10'(h0) + 10'(h1) + 10'(h2)) >> 2);
    end
  end

  // Handshake monitor, sampled mid-low-phase when inputs and outputs are settled
  always begin
    @(negedge Clk);
    #2;
    cyc++;
    if (In_valid && In_ready) acc_cyc.push_back(cyc);
    if (Out_valid && Out_ready) begin out_q.push_back(Out_data); out_cyc.push_back(cyc); end
    if (Out_valid) ov_seen = 1'b1;
    if (Ma_clear) clr_cnt++;
    if (Ma_clear && Ma_enable) both_hi++;
  end

  initial begin #300000; $display("FAIL watchdog: simulation did not finish"); $fatal(1); end

  task automatic clr();
    acc_cyc.delete(); out_cyc.delete(); out_q.delete(); ov_seen = 1'b0; clr_cnt = 0;
  endtask

  task automatic start_run();
    clr();
    Start = 1'b1; @(negedge Clk); Start = 1'b0; @(negedge Clk);
  endtask

  task automatic send(input logic [7:0] v, input logic stp);
    int n = 0;
    In_valid = 1'b1; In_data = v;
    while (In_ready !== 1'b1 && n < 20) begin @(negedge Clk); n++; end
    checks++;
    if (In_ready !== 1'b1) begin fails++; $display("FAIL send_ready: sample %0d not accepted within %0d cycles", v, n); end
    Stop = stp;
    @(negedge Clk);
    In_valid = 1'b0; Stop = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (Busy !== 1'b0 && n < 40) begin @(negedge Clk); n++; end
    checks++;
    if (Busy !== 1'b0) begin fails++; $display("FAIL wait_idle: Busy=%b after %0d cycles, expected 0", Busy, n); end
  endtask

  task automatic test_reset();
    Reset_n = 1'b0;
    repeat (2) @(negedge Clk);
    checks++;
    if ({In_ready, Ma_clear, Ma_enable, Out_valid, Busy} !== 5'b0) begin fails++; $display("FAIL reset_flags: got %b expected 00000", {In_ready, Ma_clear, Ma_enable, Out_valid, Busy}); end
    checks++;
    if ({Ma_X1, Out_data, Sample_count} !== 32'h0) begin fails++; $display("FAIL reset_data: got %h expected 0", {Ma_X1, Out_data, Sample_count}); end
    Reset_n = 1'b1;
    @(negedge Clk);
    checks++;
    if (Busy !== 1'b0 || In_ready !== 1'b0) begin fails++; $display("FAIL idle_after_reset: Busy=%b In_ready=%b expected 0 0", Busy, In_ready); end
    clr();
    Start = 1'b1; @(negedge Clk); Start = 1'b0;
    checks++;
    if (Ma_clear !== 1'b1 || Busy !== 1'b1 || In_ready !== 1'b0) begin fails++; $display("FAIL clear_cycle: Ma_clear=%b Busy=%b In_ready=%b expected 1 1 0", Ma_clear, Busy, In_ready); end
    @(negedge Clk);
    checks++;
    if (Ma_clear !== 1'b0 || In_ready !== 1'b1) begin fails++; $display("FAIL fill_entry: Ma_clear=%b In_ready=%b expected 0 1", Ma_clear, In_ready); end
    Stop = 1'b1; @(negedge Clk); Stop = 1'b0;
    wait_idle();
    checks++;
    if (clr_cnt !== 1) begin fails++; $display("FAIL clear_width: %0d cycles expected 1", clr_cnt); end
  endtask

  task automatic test_warmup();
    logic [7:0] s[5] = '{8'd4, 8'd8, 8'd12, 8'd16, 8'd20};
    Out_ready = 1'b1;
    start_run();
    foreach (s[i]) send(s[i], 1'b0);
    repeat (6) @(negedge Clk);
    checks++;
    if (out_q.size() != 2) begin fails++; $display("FAIL warmup_count: got %0d results expected 2", out_q.size()); end
    checks++;
    if ((out_q.size() > 0 ? int'(out_q[0]) : -1) != 10) begin fails++; $display("FAIL warmup_first: got %0d expected 10", out_q.size() > 0 ? int'(out_q[0]) : -1); end
    checks++;
    if ((out_q.size() > 1 ? int'(out_q[1]) : -1) != 14) begin fails++; $display("FAIL warmup_second: got %0d expected 14", out_q.size() > 1 ? int'(out_q[1]) : -1); end
    checks++;
    if (out_cyc.size() < 1 || acc_cyc.size() < 4 || out_cyc[0] - acc_cyc[3] != 3) begin fails++; $display("FAIL warmup_latency: got %0d cycles expected 3", (out_cyc.size() > 0 && acc_cyc.size() > 3) ? out_cyc[0] - acc_cyc[3] : -1); end
    checks++;
    if (acc_cyc.size() != 5 || acc_cyc[4] - acc_cyc[0] != 4) begin fails++; $display("FAIL warmup_throughput: %0d accepts, span %0d expected 5 accepts span 4", acc_cyc.size(), acc_cyc.size() == 5 ? acc_cyc[4] - acc_cyc[0] : -1); end
    checks++;
    if (Sample_count !== 16'd5) begin fails++; $display("FAIL warmup_sample_count: got %0d expected 5", Sample_count); end
    Start = 1'b1; @(negedge Clk); Start = 1'b0;
    checks++;
    if (Ma_clear !== 1'b0 || Busy !== 1'b1 || Sample_count !== 16'd5) begin fails++; $display("FAIL start_in_run: Ma_clear=%b Busy=%b count=%0d expected 0 1 5", Ma_clear, Busy, Sample_count); end
    Stop = 1'b1; @(negedge Clk); Stop = 1'b0;
    wait_idle();
    checks++;
    if (Sample_count !== 16'd5) begin fails++; $display("FAIL count_hold_idle: got %0d expected 5", Sample_count); end
  endtask

  task automatic test_backpressure();
    logic [7:0] exp[5] = '{8'd20, 8'd28, 8'd36, 8'd44, 8'd52};
    Out_ready = 1'b0;
    start_run();
    for (int i = 1; i <= 6; i++) send(8'(8 * i), 1'b0);
    In_valid = 1'b1; In_data = 8'd56;
    repeat (4) begin
      checks++;
      if (In_ready !== 1'b0 || Out_valid !== 1'b1 || Out_data !== 8'd20) begin fails++; $display("FAIL bp_stall: In_ready=%b Out_valid=%b Out_data=%0d expected 0 1 20", In_ready, Out_valid, Out_data); end
      @(negedge Clk);
    end
    checks++;
    if (out_q.size() != 0 || acc_cyc.size() != 6) begin fails++; $display("FAIL bp_held: results=%0d accepts=%0d expected 0 6", out_q.size(), acc_cyc.size()); end
    In_valid = 1'b0;
    Out_ready = 1'b1;
    send(8'd56, 1'b0);
    send(8'd64, 1'b0);
    repeat (8) @(negedge Clk);
    checks++;
    if (out_q.size() != 5) begin fails++; $display("FAIL bp_count: got %0d results expected 5", out_q.size()); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ((out_q.size() > i ? int'(out_q[i]) : -1) != int'(exp[i])) begin fails++; $display("FAIL bp_order[%0d]: got %0d expected %0d", i, out_q.size() > i ? int'(out_q[i]) : -1, exp[i]); end
    end
    Stop = 1'b1; @(negedge Clk); Stop = 1'b0;
    wait_idle();
  endtask

  task automatic test_stop_fill();
    Out_ready = 1'b1;
    clr();
    Stop = 1'b1; @(negedge Clk); Stop = 1'b0;
    checks++;
    if (Busy !== 1'b0) begin fails++; $display("FAIL stop_in_idle: Busy=%b expected 0", Busy); end
    Start = 1'b1; Stop = 1'b1; @(negedge Clk); Start = 1'b0; Stop = 1'b0;
    checks++;
    if (Ma_clear !== 1'b1) begin fails++; $display("FAIL start_wins: Ma_clear=%b expected 1", Ma_clear); end
    @(negedge Clk);
    send(8'd50, 1'b0);
    send(8'd60, 1'b0);
    Stop = 1'b1; @(negedge Clk); Stop = 1'b0;
    checks++;
    if (Busy !== 1'b1 || In_ready !== 1'b0) begin fails++; $display("FAIL fill_drain: Busy=%b In_ready=%b expected 1 0", Busy, In_ready); end
    wait_idle();
    checks++;
    if (ov_seen !== 1'b0 || out_q.size() != 0) begin fails++; $display("FAIL fill_no_output: Out_valid seen=%b results=%0d expected 0 0", ov_seen, out_q.size()); end
    checks++;
    if (Sample_count !== 16'd2) begin fails++; $display("FAIL fill_count: got %0d expected 2", Sample_count); end
  endtask

  task automatic test_stop_accept();
    Out_ready = 1'b1;
    start_run();
    for (int i = 1; i <= 5; i++) send(8'(4 * i), 1'b0);
    send(8'd24, 1'b1);
    wait_idle();
    checks++;
    if (out_q.size() != 3) begin fails++; $display("FAIL stop_acc_count: got %0d results expected 3", out_q.size()); end
    checks++;
    if ((out_q.size() > 2 ? int'(out_q[2]) : -1) != 18) begin fails++; $display("FAIL stop_acc_last: got %0d expected 18", out_q.size() > 2 ? int'(out_q[2]) : -1); end
    checks++;
    if (Sample_count !== 16'd6) begin fails++; $display("FAIL stop_acc_sample_count: got %0d expected 6", Sample_count); end
  endtask

  task automatic test_reset_mid();
    Out_ready = 1'b0;
    start_run();
    for (int i = 1; i <= 6; i++) send(8'(8 * i), 1'b0);
    checks++;
    if (Out_valid !== 1'b1) begin fails++; $display("FAIL mid_prefill: Out_valid=%b expected 1", Out_valid); end
    Reset_n = 1'b0;
    #1;
    checks++;
    if (Out_valid !== 1'b0 || Busy !== 1'b0 || In_ready !== 1'b0 || Out_data !== 8'd0) begin fails++; $display("FAIL mid_reset: Out_valid=%b Busy=%b In_ready=%b Out_data=%0d expected 0 0 0 0", Out_valid, Busy, In_ready, Out_data); end
    @(negedge Clk);
    Reset_n = 1'b1;
    Out_ready = 1'b1;
    @(negedge Clk);
    start_run();
    for (int i = 0; i < 3; i++) send(8'd4, 1'b0);
    repeat (3) @(negedge Clk);
    checks++;
    if (out_q.size() != 0) begin fails++; $display("FAIL mid_warmup: got %0d results expected 0", out_q.size()); end
    send(8'd4, 1'b0);
    repeat (5) @(negedge Clk);
    checks++;
    if (out_q.size() != 1 || out_q[0] !== 8'd4) begin fails++; $display("FAIL mid_first: got %0d results first %0d expected 1 result of 4", out_q.size(), out_q.size() > 0 ? int'(out_q[0]) : -1); end
    checks++;
    if (clr_cnt != 1) begin fails++; $display("FAIL mid_clear: %0d clear cycles expected 1", clr_cnt); end
    checks++;
    if (out_cyc.size() < 1 || acc_cyc.size() < 4 || out_cyc[0] - acc_cyc[3] != 3) begin fails++; $display("FAIL mid_latency: got %0d expected 3", (out_cyc.size() > 0 && acc_cyc.size() > 3) ? out_cyc[0] - acc_cyc[3] : -1); end
    Stop = 1'b1; @(negedge Clk); Stop = 1'b0;
    wait_idle();
    checks++;
    if (both_hi != 0) begin fails++; $display("FAIL clear_enable_overlap: %0d cycles expected 0", both_hi); end
  endtask

  initial begin
    test_reset();
    test_warmup();
    test_backpressure();
    test_stop_fill();
    test_stop_accept();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
